pipe_stage_reg: RTL

Parametrised, handshaked pipeline stage register for the LCA processor. It replaces the fixed, always-loading per-stage register bundles between IF/ID/RR/EX/MEM/WB. It carries one packed payload word with a valid bit, and adds valid/ready flow control, stall back-pressure and flush (bubble insertion). An optional skid buffer gives a fully registered ready path.

---
 rtl/pipe_pkg.sv | 72 +++++++
 rtl/pipe_skid_entry.sv | 33 +++
 rtl/pipe_stage_reg.sv | 95 +++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: stage payload bundles and widths for the LCA pipeline.
// Bundles are packed so each stage register carries one flat word.
package pipe_pkg;

  localparam int OCC_W = 2;

  typedef struct packed {
    logic [15:0] Instr;
    logic [15:0] PC;
    logic [15:0] PCInc;
  } if_id_t;

  typedef struct packed {
    logic [15:0] Instr;
    logic [15:0] PC;
    logic [15:0] PCInc;
    logic [15:0] Imm;
    logic [3:0]  AluOp;
    logic [2:0]  WriteAdd;
    logic        RegWrite;
    logic        MemRead;
    logic        MemWrite;
  } id_rr_t;

  typedef struct packed {
    logic [15:0] Data1;
    logic [15:0] Data2;
    logic [15:0] Imm;
    logic [15:0] PC;
    logic [15:0] PCInc;
    logic [3:0]  AluOp;
    logic [2:0]  WriteAdd;
    logic        RegWrite;
    logic        MemRead;
    logic        MemWrite;
  } rr_ex_t;

  typedef struct packed {
    logic [15:0] ALUOut;
    logic [15:0] StoreData;
    logic [15:0] PCInc;
    logic [15:0] PCImmInc;
    logic [2:0]  WriteAdd;
    logic [1:0]  CCR;
    logic        CCRWrite;
    logic        MemRead;
    logic        MemWrite;
    logic        WriteRF;
  } ex_mem_t;

  typedef struct packed {
    logic [15:0] MemData;
    logic [15:0] Imm970s;
    logic [15:0] PCImmInc;
    logic [15:0] ALUOut;
    logic [15:0] PCInc;
    logic [2:0]  WriteAdd;
    logic [1:0]  R7WriteSelect;
    logic [1:0]  RegWriteSelect;
    logic [1:0]  CCR;
    logic        CCRWrite;
    logic        WriteRF;
    logic        WriteR7;
  } mem_wb_t;

  localparam int IF_ID_W  = $bits(if_id_t);
  localparam int ID_RR_W  = $bits(id_rr_t);
  localparam int RR_EX_W  = $bits(rr_ex_t);
  localparam int EX_MEM_W = $bits(ex_mem_t);
  localparam int MEM_WB_W = $bits(mem_wb_t);

endpackage

// File: rtl/pipe_skid_entry.sv
// pipe_skid_entry: one valid+payload flop. Priority flush > load > clear.
// Ports: clk, reset(async low), load, clear, flush, loadData -> valid, data.
module pipe_skid_entry #(
  parameter int              WIDTH          = 16,
  parameter logic [WIDTH-1:0] RESET_VAL     = '0,
  parameter bit              CLEAR_ON_FLUSH = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic             flush,
  input  logic [WIDTH-1:0] loadData,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      data  <= RESET_VAL;
    end else if (flush) begin
      valid <= 1'b0;
      if (CLEAR_ON_FLUSH) data <= RESET_VAL;
    end else if (load) begin
      valid <= 1'b1;
      data  <= loadData;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready stage register with flush; macro PIPE_SKID_EN
// adds a skid entry and registered in_ready. Ports: clk, reset(async low),
// in_valid/in_data/in_ready, out_valid/out_data/out_ready, flush, occupancy.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH          = 16,
  parameter logic [WIDTH-1:0] RESET_VAL      = '0,
  parameter bit               CLEAR_ON_FLUSH = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  output logic [OCC_W-1:0] occupancy
);

  logic             upXfer;
  logic             downXfer;
  logic             mainValid;
  logic             mainLoad;
  logic             mainClear;
  logic [WIDTH-1:0] mainIn;
  logic [WIDTH-1:0] mainData;

  assign upXfer    = in_valid && in_ready;
  assign downXfer  = mainValid && out_ready;
  assign out_valid = mainValid;
  assign out_data  = mainData;

`ifdef PIPE_SKID_EN
  logic             skidValid;
  logic             skidLoad;
  logic             skidClear;
  logic             mainFree;
  logic [WIDTH-1:0] skidData;

  // in_ready comes straight from the skid valid flop: no comb path
  // from out_ready back upstream.
  assign in_ready  = !skidValid;
  assign mainFree  = !mainValid || out_ready;

  // A waiting skid beat is older than anything arriving now.
  assign mainLoad  = mainFree && (skidValid || upXfer);
  assign mainIn    = skidValid ? skidData : in_data;
  assign mainClear = downXfer;

  assign skidLoad  = upXfer && (skidValid || !mainFree);
  assign skidClear = skidValid && mainFree;

  assign occupancy = {1'b0, mainValid} + {1'b0, skidValid};

  pipe_skid_entry #(
    .WIDTH         (WIDTH),
    .RESET_VAL     (RESET_VAL),
    .CLEAR_ON_FLUSH(CLEAR_ON_FLUSH)
  ) uSkid (
    .clk     (clk),
    .reset   (reset),
    .load    (skidLoad),
    .clear   (skidClear),
    .flush   (flush),
    .loadData(in_data),
    .valid   (skidValid),
    .data    (skidData)
  );
`else
  assign in_ready  = out_ready || !mainValid;
  assign mainLoad  = upXfer;
  assign mainIn    = in_data;
  assign mainClear = downXfer;
  assign occupancy = {1'b0, mainValid};
`endif

  pipe_skid_entry #(
    .WIDTH         (WIDTH),
    .RESET_VAL     (RESET_VAL),
    .CLEAR_ON_FLUSH(CLEAR_ON_FLUSH)
  ) uMain (
    .clk     (clk),
    .reset   (reset),
    .load    (mainLoad),
    .clear   (mainClear),
    .flush   (flush),
    .loadData(mainIn),
    .valid   (mainValid),
    .data    (mainData)
  );

endmodule
